traffic_lane: RTL
=================

Name: traffic_lane

Overview:
- Parametrised successor to the single-car mover: one road lane containing NUM_CARS cars that share one step timer, speed and direction.
- Adds true modular wrap, a difficulty level that shortens the step period, an enable/pause, a restart, a one-cycle step strobe and a registered frog-collision flag.
- Sits between the game controller, which drives enable, level, restart and frog position, and the sprite renderer, which consumes o_car_x.

Parameters:
- NUM_CARS, 3: cars in the lane (1..8).
- X_W, 5: bit width of one x position.
- GRID_MAX, 20: highest column; legal positions are 0..GRID_MAX, and GRID_MAX < 2^X_W.
- CAR_SPEED, 1: columns moved per step (1..GRID_MAX).
- CAR_DIRECTION, 1: 1 means x increases, 0 means x decreases.
- TICK_PERIOD, 6250000: clocks per step at level 0 (≥1).
- TICK_W, 23: tick counter width, with TICK_PERIOD < 2^TICK_W.
- LEVEL_W, 2: width of i_level.
- CAR_STARTS, {5'd14,5'd7,5'd0}: packed NUM_CARS*X_W start positions, car 0 in the LSBs; each value ≤ GRID_MAX.

Ports:
- i_Clk, in, 1: system clock, 25 MHz.
- i_Reset, in, 1: synchronous, active-high reset.
- i_enable, in, 1: movement allowed; when low, the timer and positions hold.
- i_level, in, LEVEL_W: difficulty; effective period P = max(1, TICK_PERIOD >> i_level).
- i_restart, in, 1: reload start positions and clear the timer.
- i_frog_x, in, X_W: frog column.
- i_frog_in_lane, in, 1: frog row equals this lane.
- o_car_x, out, NUM_CARS*X_W: packed car positions, car k in bits [k*X_W +: X_W].
- o_step, out, 1: one-cycle pulse, high in the cycle the new positions first appear.
- o_hit, out, 1: frog collides with any car.

Behaviour:
- Reset (i_Reset=1 at a clock edge):
  - o_car_x = CAR_STARTS; tick counter = 0; o_step = 0; o_hit = 0.
  - Reset overrides every other input.
- Priority at each edge: reset > restart > step > count/hold.
- Timer:
  - If i_enable=1 and counter < P-1, the counter increments.
  - If i_enable=1 and counter ≥ P-1, a step fires and the counter goes to 0.
  - If i_enable=0, the counter and positions hold and o_step = 0.
  - The ≥ compare covers a level change mid-count: if the new P-1 ≤ counter, the step fires on the next enabled edge.
- Step: all cars update in the same edge, o_step = 1 for exactly that following cycle, and o_step = 0 otherwise.
- Position arithmetic is done in X_W+1 bits so there is no overflow:
  - Direction 1: if x + CAR_SPEED > GRID_MAX, x' = x + CAR_SPEED − (GRID_MAX+1); else x' = x + CAR_SPEED.
  - Direction 0: if x < CAR_SPEED, x' = x + (GRID_MAX+1) − CAR_SPEED; else x' = x − CAR_SPEED.
  - Positions therefore always stay in 0..GRID_MAX, and spacing between cars is preserved modulo GRID_MAX+1.
- Restart (i_restart=1, no reset):
  - o_car_x = CAR_STARTS, counter = 0, o_step = 0.
  - A step due in the same cycle is discarded.
  - Restart works regardless of i_enable.
- Collision:
  - o_hit is registered: o_hit(n+1) = i_frog_in_lane(n) AND OR over k of (o_car_x[k](n) == i_frog_x(n)).
  - Latency is one cycle from any change in car positions or frog inputs.
  - o_hit is evaluated even when i_enable=0.
  - o_hit = 0 on the edge where reset is applied.
  - o_hit is evaluated normally on restart, using the pre-restart positions.
- Duplicate or overlapping cars are legal, and o_hit still reports a hit.
- P = 1 (including the clamp when TICK_PERIOD >> i_level = 0) steps on every enabled cycle, and o_step stays high continuously.

Test Plan (bench parameters: TICK_PERIOD=4, defaults otherwise unless noted):
1. Release reset, i_enable=1, i_level=0 → o_car_x stays {14,7,0} until the 4th edge after release. After that edge, o_car_x = {15,8,1} with o_step=1 for one cycle. o_step then repeats every 4 cycles.
2. Wrap, CAR_SPEED=3:
   - CAR_DIRECTION=1, car at 19 → 1; car at 18 → 0.
   - CAR_DIRECTION=0, car at 1 → 19; car at 3 → 0.
   - No value ever exceeds 20.
3. Pause: drop i_enable for 10 cycles when the counter is 2 → no o_step and positions held. After re-enable, the step fires on the 2nd enabled edge.
4. Level changes:
   - i_level=1 → step every 2 cycles.
   - i_level=2 or 3 → P clamps to 1, so a step every cycle and o_step stays high.
   - Switch from level 0 to level 2 with counter=3 → step on the next edge.
5. Collision: i_frog_x=8, i_frog_in_lane=1, cars stepping from 7 → o_hit=1 exactly one cycle after o_car_x shows 8. Repeat with i_frog_in_lane=0 → o_hit stays 0.
6. Restart and reset:
   - Assert i_restart on a step edge → o_car_x = {14,7,0}, o_step=0, and the next step comes P cycles later.
   - Assert i_Reset mid-count with i_restart=1 → reset values result, and o_hit=0.

Source files
------------

// File: rtl/traffic_lane.sv
// One road lane of NUM_CARS cars that share a step timer, speed and direction.
// Positions wrap modulo GRID_MAX+1. o_step marks the cycle new positions appear; o_hit is registered.
module traffic_lane #(
    parameter int NUM_CARS      = 3,
    parameter int X_W           = 5,
    parameter int GRID_MAX      = 20,
    parameter int CAR_SPEED     = 1,
    parameter int CAR_DIRECTION = 1,
    parameter int TICK_PERIOD   = 6250000,
    parameter int TICK_W        = 23,
    parameter int LEVEL_W       = 2,
    parameter logic [NUM_CARS*X_W-1:0] CAR_STARTS = {5'd14, 5'd7, 5'd0}
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic                    i_enable,
    input  logic [LEVEL_W-1:0]      i_level,
    input  logic                    i_restart,
    input  logic [X_W-1:0]          i_frog_x,
    input  logic                    i_frog_in_lane,
    output logic [NUM_CARS*X_W-1:0] o_car_x,
    output logic                    o_step,
    output logic                    o_hit
);

    localparam logic [TICK_W-1:0] PERIOD0 = TICK_W'(TICK_PERIOD);
    localparam logic [X_W:0]      SPEED_E = (X_W+1)'(CAR_SPEED);
    localparam logic [X_W:0]      GRID_E  = (X_W+1)'(GRID_MAX);
    localparam logic [X_W:0]      WRAP_E  = (X_W+1)'(GRID_MAX + 1);

    // One column step with modular wrap; the extra bit keeps x+speed from overflowing.
    function automatic logic [X_W-1:0] advance(input logic [X_W-1:0] x);
        logic [X_W:0] xe;
        logic [X_W:0] r;
        xe = {1'b0, x};
        if (CAR_DIRECTION != 0) begin
            r = xe + SPEED_E;
            if (r > GRID_E) begin
                r = r - WRAP_E;
            end
        end else begin
            if (xe < SPEED_E) begin
                r = xe + WRAP_E - SPEED_E;
            end else begin
                r = xe - SPEED_E;
            end
        end
        return X_W'(r);
    endfunction

    logic [NUM_CARS*X_W-1:0] car_q, car_d;
    logic [TICK_W-1:0]       cnt_q, cnt_d;
    logic                    step_q, step_d;
    logic                    hit_q, hit_d;

    logic [TICK_W-1:0]       period_shr;
    logic [TICK_W-1:0]       last_cnt;
    logic                    step_due;
    logic                    any_match;

    // Level shortens the period; a zero result clamps to P=1 (last count 0).
    assign period_shr = PERIOD0 >> i_level;
    assign last_cnt   = (period_shr == '0) ? '0 : period_shr - TICK_W'(1);
    // >= rather than == so a level raised mid-count still fires promptly.
    assign step_due   = i_enable && (cnt_q >= last_cnt);

    always_comb begin
        any_match = 1'b0;
        for (int k = 0; k < NUM_CARS; k++) begin
            if (car_q[k*X_W +: X_W] == i_frog_x) begin
                any_match = 1'b1;
            end
        end
        hit_d = i_frog_in_lane & any_match;
    end

    always_comb begin
        car_d  = car_q;
        cnt_d  = cnt_q;
        step_d = 1'b0;
        if (i_restart) begin
            car_d = CAR_STARTS;
            cnt_d = '0;
        end else if (step_due) begin
            for (int k = 0; k < NUM_CARS; k++) begin
                car_d[k*X_W +: X_W] = advance(car_q[k*X_W +: X_W]);
            end
            cnt_d  = '0;
            step_d = 1'b1;
        end else if (i_enable) begin
            cnt_d = cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            car_q  <= CAR_STARTS;
            cnt_q  <= '0;
            step_q <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            car_q  <= car_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
            hit_q  <= hit_d;
        end
    end

    assign o_car_x = car_q;
    assign o_step  = step_q;
    assign o_hit   = hit_q;

endmodule
